// File: rtl/jtag_shift_master_if.sv
// Command/response channel of the JTAG shift master.
// The command producer holds the master modport and the shift engine holds the slave modport.
interface jtag_shift_master_if #(
  parameter int unsigned MAX_BITS = 32
) ();
  localparam int unsigned LenW = $clog2(MAX_BITS) + 1;

  logic                cmd_valid;
  logic                cmd_accept;
  logic [LenW-1:0]     cmd_len;
  logic [MAX_BITS-1:0] cmd_tms;
  logic [MAX_BITS-1:0] cmd_tdi;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_data;
  logic                rsp_accept;

  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_accept,
    input  cmd_accept, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_accept,
    output cmd_accept, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_shift_master.sv
// JTAG initiator: shifts one command of TMS/TDI bits out on TCK and returns the captured TDO
// vector on a valid/accept response channel.
module jtag_shift_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned MAX_BITS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  jtag_shift_master_if.slave bus,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  input  logic              jtag_tdo_i,
  output logic              busy_o
);
  localparam int unsigned LenW = $clog2(MAX_BITS) + 1;
  localparam int unsigned IdxW = $clog2(MAX_BITS);
  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(CLK_DIV - 1);
  localparam logic [LenW-1:0] MaxLen  = LenW'(MAX_BITS);

  typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [MAX_BITS-1:0] tms_vec_q, tms_vec_d;
  logic [MAX_BITS-1:0] tdi_vec_q, tdi_vec_d;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [LenW-1:0]     len_eff;

  assign len_eff = (bus.cmd_len > MaxLen) ? MaxLen : bus.cmd_len;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    tms_vec_d   = tms_vec_q;
    tdi_vec_d   = tdi_vec_q;
    data_d      = data_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          tms_vec_d = bus.cmd_tms;
          tdi_vec_d = bus.cmd_tdi;
          len_d     = len_eff;
          data_d    = '0;
          idx_d     = '0;
          cnt_d     = CntLoad;
          if (len_eff == '0) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = StShiftLo;
            tck_d   = 1'b0;
            tms_d   = bus.cmd_tms[0];
            tdi_d   = bus.cmd_tdi[0];
          end
        end
      end
      StShiftLo: begin
        if (cnt_q == '0) begin
          state_d        = StShiftHi;
          tck_d          = 1'b1;
          cnt_d          = CntLoad;
          // TDO is sampled on the same clk_i edge that raises TCK.
          data_d[idx_q]  = jtag_tdo_i;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StShiftHi: begin
        if (cnt_q == '0) begin
          tck_d = 1'b0;
          cnt_d = CntLoad;
          if (LenW'(idx_q) == len_q - LenW'(1)) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = StShiftLo;
            idx_d   = idx_q + IdxW'(1);
            tms_d   = tms_vec_q[idx_d];
            tdi_d   = tdi_vec_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_accept) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      tms_vec_q   <= '0;
      tdi_vec_q   <= '0;
      data_q      <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      tms_vec_q   <= tms_vec_d;
      tdi_vec_q   <= tdi_vec_d;
      data_q      <= data_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.cmd_accept = (state_q == StIdle) & ~rst_i;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = data_q;
  assign jtag_tck_o     = tck_q;
  assign jtag_tms_o     = tms_q;
  assign jtag_tdi_o     = tdi_q;
  assign busy_o         = (state_q != StIdle);
endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master with TDO looped back to TDI; cycle 1 is the first
// negedge after the command accept edge.
module tb_jtag_shift_master;
  localparam int unsigned ClkDiv  = 2;
  localparam int unsigned MaxBits = 32;
  localparam int unsigned LenW    = $clog2(MaxBits) + 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, busy;

  jtag_shift_master_if #(.MAX_BITS(MaxBits)) bus ();

  assign jtag_tdo = jtag_tdi;

  jtag_shift_master #(
    .CLK_DIV  (ClkDiv),
    .MAX_BITS (MaxBits)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus),
    .jtag_tck_o (jtag_tck),
    .jtag_tms_o (jtag_tms),
    .jtag_tdi_o (jtag_tdi),
    .jtag_tdo_i (jtag_tdo),
    .busy_o     (busy)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int waits, cyc, pulses, first_rise, tms_err, err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present a command and wait for it to be taken; returns at the negedge after the accept edge.
  task automatic send_cmd(input int len, input logic [31:0] tms, input logic [31:0] tdi,
                          output int n_wait);
    bus.cmd_len   = LenW'(len);
    bus.cmd_tms   = tms;
    bus.cmd_tdi   = tdi;
    bus.cmd_valid = 1'b1;
    n_wait        = 0;
    while (!bus.cmd_accept && n_wait < 50) begin
      @(posedge clk_i);
      @(negedge clk_i);
      bus.rsp_accept = 1'b0;
      n_wait++;
    end
    if (!bus.cmd_accept) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    // Scramble inputs: they must be ignored once the command is taken.
    bus.cmd_valid = 1'b0;
    bus.cmd_tms   = ~tms;
    bus.cmd_tdi   = ~tdi;
    bus.cmd_len   = LenW'(7);
  endtask

  task automatic wait_rsp(input logic [31:0] tms_exp, input int budget,
                          output int c, output int p, output int fr, output int te);
    logic prev;
    prev = 1'b0;
    c = 1; p = 0; fr = -1; te = 0;
    while (c <= budget) begin
      if (jtag_tck && !prev) begin
        if (p == 0) fr = c;
        if (p < 32 && jtag_tms !== tms_exp[p]) te++;
        p++;
      end
      prev = jtag_tck;
      if (bus.rsp_valid) break;
      @(negedge clk_i);
      c++;
    end
    if (c > budget) c = -1;
  endtask

  task automatic finish_rsp(input string tag);
    bus.rsp_accept = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.rsp_accept = 1'b0;
    check({tag, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_len    = '0;
    bus.cmd_tms    = '0;
    bus.cmd_tdi    = '0;
    bus.rsp_accept = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_tck", 64'(jtag_tck), 64'd0);
    check("rst_tms", 64'(jtag_tms), 64'd1);
    check("rst_tdi", 64'(jtag_tdi), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_accept", 64'(bus.cmd_accept), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_accept", 64'(bus.cmd_accept), 64'd1);

    // Five TMS-high pulses.
    send_cmd(5, 32'h1F, 32'h0, waits);
    check("t2_wait", 64'(waits), 64'd0);
    wait_rsp(32'h1F, 500, cyc, pulses, first_rise, tms_err);
    check("t2_cycle", 64'(cyc), 64'd21);
    check("t2_pulses", 64'(pulses), 64'd5);
    check("t2_first_rise", 64'(first_rise), 64'd3);
    check("t2_tms_err", 64'(tms_err), 64'd0);
    check("t2_data", 64'(bus.rsp_data), 64'd0);
    check("t2_tms_after", 64'(jtag_tms), 64'd1);
    check("t2_tck_after", 64'(jtag_tck), 64'd0);
    check("t2_accept_resp", 64'(bus.cmd_accept), 64'd0);
    finish_rsp("t2");

    // Loopback of A5.
    send_cmd(8, 32'h0, 32'hA5, waits);
    wait_rsp(32'h0, 500, cyc, pulses, first_rise, tms_err);
    check("t3_cycle", 64'(cyc), 64'd33);
    check("t3_pulses", 64'(pulses), 64'd8);
    check("t3_data", 64'(bus.rsp_data), 64'hA5);
    check("t3_tms_after", 64'(jtag_tms), 64'd0);
    check("t3_tdi_after", 64'(jtag_tdi), 64'd1);
    finish_rsp("t3");

    // Response stall, then accept with a new command in the same cycle.
    send_cmd(3, 32'h5, 32'h6, waits);
    wait_rsp(32'h5, 500, cyc, pulses, first_rise, tms_err);
    check("t4_cycle", 64'(cyc), 64'd13);
    check("t4_data", 64'(bus.rsp_data), 64'h6);
    err = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (!bus.rsp_valid || bus.rsp_data !== 32'h6 || jtag_tck || bus.cmd_accept) err++;
    end
    check("t4_stall_err", 64'(err), 64'd0);
    bus.rsp_accept = 1'b1;
    send_cmd(2, 32'h2, 32'h1, waits);
    check("t4_bubble", 64'(waits), 64'd1);
    wait_rsp(32'h2, 500, cyc, pulses, first_rise, tms_err);
    check("t4b_cycle", 64'(cyc), 64'd9);
    check("t4b_first_rise", 64'(first_rise), 64'd3);
    check("t4b_pulses", 64'(pulses), 64'd2);
    check("t4b_tms_err", 64'(tms_err), 64'd0);
    check("t4b_data", 64'(bus.rsp_data), 64'h1);
    finish_rsp("t4b");

    // Zero-length and over-length commands.
    send_cmd(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, waits);
    wait_rsp(32'h0, 500, cyc, pulses, first_rise, tms_err);
    check("t5_len0_cycle", 64'(cyc), 64'd1);
    check("t5_len0_pulses", 64'(pulses), 64'd0);
    check("t5_len0_data", 64'(bus.rsp_data), 64'd0);
    finish_rsp("t5a");
    send_cmd(40, 32'h0F0F_0F0F, 32'hDEAD_BEEF, waits);
    wait_rsp(32'h0F0F_0F0F, 500, cyc, pulses, first_rise, tms_err);
    check("t5_len40_cycle", 64'(cyc), 64'd129);
    check("t5_len40_pulses", 64'(pulses), 64'd32);
    check("t5_len40_tms_err", 64'(tms_err), 64'd0);
    check("t5_len40_data", 64'(bus.rsp_data), 64'hDEAD_BEEF);
    finish_rsp("t5b");

    // Reset during TCK-high of bit 3.
    send_cmd(16, 32'h0, 32'h1234, waits);
    cyc = 1;
    while (cyc < 15) begin
      @(negedge clk_i);
      cyc++;
    end
    check("t6_tck_before", 64'(jtag_tck), 64'd1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_tck", 64'(jtag_tck), 64'd0);
    check("t6_rst_tms", 64'(jtag_tms), 64'd1);
    check("t6_rst_tdi", 64'(jtag_tdi), 64'd0);
    check("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t6_rst_accept", 64'(bus.cmd_accept), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    err = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.rsp_valid || jtag_tck) err++;
    end
    check("t6_quiet", 64'(err), 64'd0);
    check("t6_accept", 64'(bus.cmd_accept), 64'd1);
    send_cmd(4, 32'h6, 32'h9, waits);
    wait_rsp(32'h6, 500, cyc, pulses, first_rise, tms_err);
    check("t6_cycle", 64'(cyc), 64'd17);
    check("t6_first_rise", 64'(first_rise), 64'd3);
    check("t6_pulses", 64'(pulses), 64'd4);
    check("t6_tms_err", 64'(tms_err), 64'd0);
    check("t6_data", 64'(bus.rsp_data), 64'h9);
    check("t6_tms_after", 64'(jtag_tms), 64'd0);
    finish_rsp("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
